// File: rtl/axi2apb_write_sequencer.sv
// Sequences one AXI write burst: commands the write-channel reader, buffers the beats it streams,
// replays them as APB writes with AXI burst addressing, then requests the B response.
module axi2apb_write_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic [1:0]              rd_cmd,
  input  logic [1:0]              rd_info,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [3:0]              a_len,
  input  logic [2:0]              a_size,
  input  logic [1:0]              a_burst,
  input  logic                    d_write,
  input  logic [DATA_WIDTH-1:0]   d_data,
  input  logic [DATA_WIDTH/8-1:0] d_strb,
  output logic [1:0]              resp,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic [1:0]              dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int SIZE_MAX   = $clog2(STRB_WIDTH);
  localparam int ENTRY_W    = DATA_WIDTH + STRB_WIDTH;

  localparam logic [1:0] INFO_BUSY   = 2'd1;
  localparam logic [1:0] INFO_SWITCH = 2'd2;

  // Reader handshake: rd_cmd is held until the reader reports BUSY; the reader reports SWITCH once
  // every beat has been streamed. APB handshake: SETUP for one cycle, then ACCESS until pready=1.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RESP} state_t;
  state_t state, state_nxt;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [ENTRY_W-1:0]    head;
  logic                  full, push, pop, overflow;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt, inc, mask;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [4:0]            len_p1, rx_cnt, done_cnt;
  logic                  err, latch, cfg_err, clr;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push     = d_write && !full;
  assign overflow = d_write && full;
  assign pop      = psel && penable && pready;
  assign head     = mem[rd_ptr];
  assign latch    = push && (rx_cnt == 5'd0);
  assign clr      = (state == S_RESP) && (rd_info == INFO_BUSY);
  assign len_p1   = {1'b0, len_q} + 5'd1;
  assign cfg_err  = (a_burst == 2'b11) || (a_size > 3'(SIZE_MAX)) ||
                    ((a_burst == 2'b10) && !wrap_len_ok(a_len));

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // Invalid WRAP lengths and the reserved encoding fall back to INCR stepping.
  always_comb begin
    inc  = ADDR_WIDTH'(1) << size_q;
    mask = (ADDR_WIDTH'(len_p1) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = wrap_len_ok(len_q) ? ((addr_q & ~mask) | ((addr_q + inc) & mask))
                                             : addr_q + inc;
      default: addr_nxt = addr_q + inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {d_data, d_strb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      rx_cnt   <= '0;
      done_cnt <= '0;
      err      <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (latch) begin
        addr_q  <= a_addr;
        len_q   <= a_len;
        size_q  <= a_size;
        burst_q <= a_burst;
      end else if (pop) begin
        addr_q  <= addr_nxt;
      end
      if (clr) begin
        rx_cnt   <= '0;
        done_cnt <= '0;
        err      <= 1'b0;
      end else begin
        if (push) rx_cnt <= rx_cnt + 5'd1;
        if (pop)  done_cnt <= done_cnt + 5'd1;
        if ((latch && cfg_err) || overflow || (pop && pslverr)) err <= 1'b1;
      end
      // A completing access rolls straight into the next SETUP while beats remain buffered.
      if (pop) begin
        psel    <= (count_nxt != '0);
        penable <= 1'b0;
      end else if (psel && !penable) begin
        penable <= 1'b1;
      end else if (!psel && (state == S_XFER) && (count != '0)) begin
        psel    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (en) state_nxt = S_REQ;
      S_REQ:  if (rd_info == INFO_BUSY) state_nxt = S_XFER;
      S_XFER: if ((done_cnt == len_p1) && (rd_info == INFO_SWITCH)) state_nxt = S_RESP;
      S_RESP: if (rd_info == INFO_BUSY) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_cmd    = 2'd0;
    resp      = 2'b00;
    busy      = (state != S_IDLE);
    dbg_state = state;
    if (state == S_REQ) rd_cmd = 2'd1;
    if (state == S_RESP) begin
      rd_cmd = 2'd2;
      resp   = err ? 2'b10 : 2'b00;
    end
  end

  assign pwrite = 1'b1;
  assign paddr  = psel ? addr_q : '0;
  assign pwdata = psel ? head[ENTRY_W-1:STRB_WIDTH] : '0;
  assign pstrb  = psel ? head[STRB_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_axi2apb_write_sequencer.sv
// Bench for axi2apb_write_sequencer: a reader model streams bursts, an APB slave model records
// writes, and each test compares them with addresses computed from the AXI burst rules.
module tb_axi2apb_write_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TW = AW + DW + SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    rd_cmd, rd_info, a_burst, resp, dbg_state;
  logic [AW-1:0] a_addr, paddr;
  logic [3:0]    a_len;
  logic [2:0]    a_size;
  logic          d_write, busy, psel, penable, pwrite, pready, pslverr;
  logic [DW-1:0] d_data, pwdata;
  logic [SW-1:0] d_strb, pstrb;

  axi2apb_write_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rd_cmd(rd_cmd), .rd_info(rd_info),
    .a_addr(a_addr), .a_len(a_len), .a_size(a_size), .a_burst(a_burst),
    .d_write(d_write), .d_data(d_data), .d_strb(d_strb), .resp(resp), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pready_wait = 0;
  int err_beat = -1;
  int apb_beat = 0;
  int wait_cnt = 0;
  int push_cnt = 0;
  int max_occ = 0;
  int timed_out = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] obs_q[$];
  logic [1:0]    got_resp, exp_resp;

  // APB slave model: waits pready_wait ACCESS cycles, then completes and records the write.
  always @(negedge clk) begin
    pready  = 1'b0;
    pslverr = 1'b0;
    if (rst_n && psel && penable) begin
      if (wait_cnt < pready_wait) wait_cnt++;
      else begin
        pready  = 1'b1;
        pslverr = (apb_beat == err_beat);
        obs_q.push_back({paddr, pwdata, pstrb});
        apb_beat++;
        wait_cnt = 0;
      end
    end
  end

  always @(posedge clk) if (push_cnt - apb_beat > max_occ) max_occ = push_cnt - apb_beat;

  // Closed-form address of beat n of an AXI burst.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] start, input int len, size, burst, n);
    logic [AW-1:0] inc, total;
    inc   = AW'(1) << size;
    total = AW'(len + 1) * inc;
    if (burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15))
      return (start & ~(total - 1)) | ((start + AW'(n) * inc) & (total - 1));
    return start + AW'(n) * inc;
  endfunction

  task automatic run_burst(input logic [AW-1:0] addr, input int len, size, burst, pw, eb, gap_max);
    int c;
    logic cfg_bad;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    apb_beat = 0; wait_cnt = 0; push_cnt = 0; max_occ = 0; timed_out = 0;
    pready_wait = pw; err_beat = eb; got_resp = 2'bxx;
    cfg_bad = (burst == 3) || (size > $clog2(SW)) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    exp_resp = (cfg_bad || (eb >= 0 && eb <= len)) ? 2'b10 : 2'b00;
    a_addr = addr; a_len = 4'(len); a_size = 3'(size); a_burst = 2'(burst); en = 1'b1;
    for (c = 0; c < 50 && rd_cmd !== 2'd1; c++) @(negedge clk);
    if (rd_cmd !== 2'd1) begin timed_out = 1; en = 1'b0; return; end
    rd_info = 2'd1; en = 1'b0;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(negedge clk); d_write = 1'b0; end
      @(negedge clk);
      d_write = 1'b1; d_data = $urandom; d_strb = SW'($urandom);
      exp_q.push_back({beat_addr(addr, len, size, burst, i), d_data, d_strb});
      push_cnt++;
    end
    @(negedge clk);
    d_write = 1'b0; rd_info = 2'd2;
    for (c = 0; c < 400 && rd_cmd !== 2'd2; c++) @(negedge clk);
    if (rd_cmd !== 2'd2) begin timed_out = 1; rd_info = 2'd0; return; end
    got_resp = resp; rd_info = 2'd1;
    @(negedge clk);
    rd_info = 2'd0;
    for (c = 0; c < 10 && busy !== 1'b0; c++) @(negedge clk);
    if (busy !== 1'b0) timed_out = 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_cmd !== 2'd0) begin n_err++; $display("FAIL reset_rd_cmd got %0d want 0", rd_cmd); end
    n_cmp++; if (resp !== 2'd0) begin n_err++; $display("FAIL reset_resp got %0d want 0", resp); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (psel !== 1'b0 || penable !== 1'b0) begin n_err++; $display("FAIL reset_psel_penable got %b%b want 00", psel, penable); end
    n_cmp++; if (pwrite !== 1'b1) begin n_err++; $display("FAIL reset_pwrite got %b want 1", pwrite); end
    n_cmp++; if (paddr !== '0 || pwdata !== '0 || pstrb !== '0) begin n_err++; $display("FAIL reset_apb_bus got %h/%h/%h want 0", paddr, pwdata, pstrb); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_incr;
    run_burst(32'h100, 3, 2, 1, 0, -1, 0);
    n_cmp++; if (timed_out !== 0) begin n_err++; $display("FAIL incr_timeout got %0d want 0", timed_out); end
    n_cmp++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL incr_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL incr_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      n_cmp++; if (obs_q[i][TW-1 -: AW] !== 32'h100 + 32'(4 * i)) begin n_err++; $display("FAIL incr_addr%0d got %h want %h", i, obs_q[i][TW-1 -: AW], 32'h100 + 32'(4 * i)); end
    end
    n_cmp++; if (got_resp !== 2'b00) begin n_err++; $display("FAIL incr_resp got %b want 00", got_resp); end
  endtask

  task automatic test_wrap_fixed;
    logic [AW-1:0] wexp [4];
    wexp[0] = 32'h38; wexp[1] = 32'h3C; wexp[2] = 32'h30; wexp[3] = 32'h34;
    run_burst(32'h38, 3, 2, 2, 1, -1, 0);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 4) begin n_err++; $display("FAIL wrap_count got %0d/%0d want 4/0", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i] || obs_q[i][TW-1 -: AW] !== wexp[i]) begin n_err++; $display("FAIL wrap_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_resp !== 2'b00) begin n_err++; $display("FAIL wrap_resp got %b want 00", got_resp); end
    run_burst(32'h200, 2, 2, 0, 0, -1, 1);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 3) begin n_err++; $display("FAIL fixed_count got %0d/%0d want 3/0", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i] || obs_q[i][TW-1 -: AW] !== 32'h200) begin n_err++; $display("FAIL fixed_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    run_burst(32'h1000, 15, 2, 1, 3, -1, 0);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 16) begin n_err++; $display("FAIL bp_count got %0d/%0d want 16/0", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (!(max_occ >= 14)) begin n_err++; $display("FAIL bp_peak_occupancy got %0d want >=14", max_occ); end
    n_cmp++; if (got_resp !== 2'b00) begin n_err++; $display("FAIL bp_resp got %b want 00", got_resp); end
  endtask

  task automatic test_error;
    run_burst(32'h300, 3, 2, 1, 1, 2, 0);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 4) begin n_err++; $display("FAIL err_count got %0d/%0d want 4/0", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL err_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_resp !== 2'b10) begin n_err++; $display("FAIL err_resp got %b want 10", got_resp); end
    run_burst(32'h340, 1, 2, 1, 0, -1, 0);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 2) begin n_err++; $display("FAIL err_clear_count got %0d/%0d want 2/0", obs_q.size(), timed_out); end
    n_cmp++; if (got_resp !== 2'b00) begin n_err++; $display("FAIL err_clear_resp got %b want 00", got_resp); end
  endtask

  task automatic test_reserved;
    run_burst(32'h500, 3, 2, 3, 0, -1, 0);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 4) begin n_err++; $display("FAIL rsvd_count got %0d/%0d want 4/0", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rsvd_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_resp !== 2'b10) begin n_err++; $display("FAIL rsvd_resp got %b want 10", got_resp); end
    run_burst(32'h600, 2, 3, 1, 0, -1, 0);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 3) begin n_err++; $display("FAIL size3_count got %0d/%0d want 3/0", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL size3_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_resp !== 2'b10) begin n_err++; $display("FAIL size3_resp got %b want 10", got_resp); end
  endtask

  task automatic test_en_hold;
    en = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || rd_cmd !== 2'd0) begin n_err++; $display("FAIL en_hold got busy=%b rd_cmd=%0d want 0/0", busy, rd_cmd); end
  endtask

  task automatic test_reset_mid;
    int c;
    obs_q.delete();
    @(negedge clk);
    apb_beat = 0; wait_cnt = 0; pready_wait = 3; err_beat = -1;
    a_addr = 32'h400; a_len = 4'd3; a_size = 3'd2; a_burst = 2'd1; en = 1'b1;
    for (c = 0; c < 50 && rd_cmd !== 2'd1; c++) @(negedge clk);
    rd_info = 2'd1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_write = 1'b1; d_data = $urandom; d_strb = SW'($urandom);
    end
    @(negedge clk);
    d_write = 1'b0;
    for (c = 0; c < 60 && !(apb_beat == 1 && psel === 1'b1 && penable === 1'b1); c++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (!(apb_beat == 1 && psel === 1'b1 && penable === 1'b1)) begin n_err++; $display("FAIL rmid_reach_access got beat=%0d psel=%b penable=%b want 1/1/1", apb_beat, psel, penable); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (psel !== 1'b0 || penable !== 1'b0) begin n_err++; $display("FAIL rmid_apb got %b%b want 00", psel, penable); end
    n_cmp++; if (rd_cmd !== 2'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_fsm got rd_cmd=%0d busy=%b want 0/0", rd_cmd, busy); end
    @(negedge clk);
    rd_info = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(32'h800, 3, 2, 1, 0, -1, 0);
    n_cmp++; if (timed_out !== 0 || obs_q.size() !== 4) begin n_err++; $display("FAIL rmid_clean_count got %0d/%0d want 4/0", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rmid_clean_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_resp !== 2'b00) begin n_err++; $display("FAIL rmid_clean_resp got %b want 00", got_resp); end
  endtask

  task automatic test_random;
    int burst, len, size, eb;
    for (int k = 0; k < 12; k++) begin
      burst = $urandom_range(0, 3);
      len   = $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 3) != 0) len = (1 << $urandom_range(1, 4)) - 1;
      size  = (burst == 3) ? $urandom_range(0, 2) : ($urandom_range(0, 5) == 0 ? 3 : $urandom_range(0, 2));
      eb    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      run_burst($urandom, len, size, burst, $urandom_range(0, 2), eb, 2);
      n_cmp++; if (timed_out !== 0 || obs_q.size() !== len + 1) begin n_err++; $display("FAIL rand%0d_count got %0d/%0d want %0d/0", k, obs_q.size(), timed_out, len + 1); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_beat%0d got %h want %h", k, i, obs_q[i], exp_q[i]); end
      end
      n_cmp++; if (got_resp !== exp_resp) begin n_err++; $display("FAIL rand%0d_resp got %b want %b", k, got_resp, exp_resp); end
    end
  endtask

  initial begin
    en = 1'b0; rd_info = 2'd0; a_addr = '0; a_len = '0; a_size = '0; a_burst = '0;
    d_write = 1'b0; d_data = '0; d_strb = '0; pready = 1'b0; pslverr = 1'b0;
    test_reset;
    test_incr;
    test_wrap_fixed;
    test_backpressure;
    test_error;
    test_reserved;
    test_en_hold;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no completion want finish before 400000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
